// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: widths, fetch FSM states and
// helpers that split an instruction word into its opcode and operand fields.
package instr_fetch_pkg;

    localparam int INSTR_W = 9;
    localparam int PC_W    = 10;
    localparam int OPC_W   = 3;

    typedef enum logic [1:0] {
        F_IDLE,
        F_WAIT,
        F_READ,
        F_DONE
    } fetch_state_t;

    typedef enum logic [OPC_W-1:0] {
        OP_0 = 3'd0,
        OP_1 = 3'd1,
        OP_2 = 3'd2,
        OP_3 = 3'd3,
        OP_4 = 3'd4,
        OP_5 = 3'd5,
        OP_6 = 3'd6,
        OP_7 = 3'd7
    } opcode_t;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] ir);
        return ir[INSTR_W-1:INSTR_W-OPC_W];
    endfunction

    function automatic logic [INSTR_W-OPC_W-1:0] operand_of(input logic [INSTR_W-1:0] ir);
        return ir[INSTR_W-OPC_W-1:0];
    endfunction

endpackage

// File: rtl/instr_fetch_program_counter.sv
// Program counter: on load it points one past the address just fetched, wrapping
// naturally at 2^PCW.
module program_counter
    import instr_fetch_pkg::*;
#(
    parameter int PCW = PC_W
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           load,
    input  logic [PCW-1:0] fetched_addr,
    output logic [PCW-1:0] pc
);

    logic [PCW-1:0] pc_q;
    logic [PCW-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = fetched_addr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch responder: answers nextIns from control by reading imem, latching
// the instruction register and advancing the PC, with branch redirect and status flags.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int IW        = INSTR_W,
    parameter int PCW       = PC_W,
    parameter int LAST_ADDR = 1023
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            nextIns,
    input  logic            branch_req,
    input  logic [PCW-1:0]  branch_target,
    output logic            imem_re,
    output logic [PCW-1:0]  imem_addr,
    input  logic [IW-1:0]   imem_data,
    output logic [2:0]      instructions,
    output logic [IW-4:0]   operand,
    output logic [PCW-1:0]  pc,
    output logic            ins_valid,
    output logic            done,
    output logic            overrun
);

    fetch_state_t   state_q, state_d;
    logic           branch_pend_q, branch_pend_d;
    logic [PCW-1:0] br_addr_q, br_addr_d;
    logic [PCW-1:0] fetch_addr_q;
    logic [IW-1:0]  ir_q;
    logic           ins_valid_q;
    logic           done_q;
    logic           overrun_q;

    logic [PCW-1:0] fetch_addr;
    logic           take;
    logic           in_read;
    logic           is_last;

    assign in_read = (state_q == F_READ);
    assign is_last = (int'(fetch_addr_q) == LAST_ADDR);

    program_counter #(
        .PCW(PCW)
    ) u_pc (
        .clock       (clock),
        .reset       (reset),
        .load        (in_read),
        .fetched_addr(fetch_addr_q),
        .pc          (pc)
    );

    always_comb begin
        state_d    = state_q;
        imem_re    = 1'b0;
        imem_addr  = '0;
        take       = 1'b0;
        fetch_addr = branch_pend_q ? br_addr_q : pc;
        case (state_q)
            F_IDLE: begin
                if (start) begin
                    state_d = F_WAIT;
                end
            end
            F_WAIT: begin
                if (nextIns) begin
                    imem_re   = 1'b1;
                    imem_addr = fetch_addr;
                    take      = 1'b1;
                    state_d   = F_READ;
                end
            end
            F_READ: begin
                state_d = is_last ? F_DONE : F_WAIT;
            end
            default: begin
                state_d = F_DONE;
            end
        endcase
    end

    // A branch arriving with the fetch that consumes the old target re-arms the latch.
    always_comb begin
        branch_pend_d = branch_pend_q;
        br_addr_d     = br_addr_q;
        if (branch_req) begin
            branch_pend_d = 1'b1;
            br_addr_d     = branch_target;
        end else if (take) begin
            branch_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= F_IDLE;
            branch_pend_q <= 1'b0;
            br_addr_q     <= '0;
            fetch_addr_q  <= '0;
            ir_q          <= '0;
            ins_valid_q   <= 1'b0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            branch_pend_q <= branch_pend_d;
            br_addr_q     <= br_addr_d;
            ins_valid_q   <= in_read;
            if (take) begin
                fetch_addr_q <= fetch_addr;
            end
            if (in_read) begin
                ir_q <= imem_data;
                if (is_last) begin
                    done_q <= 1'b1;
                end
                if (nextIns) begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign instructions = opcode_of(ir_q);
    assign operand      = operand_of(ir_q);
    assign ins_valid    = ins_valid_q;
    assign done         = done_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-level model of the fetch unit.
module tb_instr_fetch;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       nextIns;
    logic       branch_req;
    logic [9:0] branch_target;
    logic       imem_re;
    logic [9:0] imem_addr;
    logic [8:0] imem_data;
    logic [2:0] instructions;
    logic [5:0] operand;
    logic [9:0] pc;
    logic       ins_valid;
    logic       done;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    logic [8:0] mem [1024];

    // model of the fetch unit at transaction level
    bit         m_started, m_ended, m_inflight, m_iv, m_ovr, m_bp;
    int         m_fa, m_pc, m_ba;
    logic [8:0] m_ir;

    logic       s_re;
    logic [9:0] s_addr;

    instr_fetch dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .nextIns      (nextIns),
        .branch_req   (branch_req),
        .branch_target(branch_target),
        .imem_re      (imem_re),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .instructions (instructions),
        .operand      (operand),
        .pc           (pc),
        .ins_valid    (ins_valid),
        .done         (done),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (imem_re) imem_data <= mem[imem_addr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_ended = 0; m_inflight = 0; m_iv = 0; m_ovr = 0; m_bp = 0;
        m_fa = 0; m_pc = 0; m_ba = 0; m_ir = '0;
    endtask

    // One clock cycle: drive, compare against model, advance model, move to next negedge.
    task automatic cyc(input bit rs, input bit st, input bit ni, input bit br, input int tg);
        bit exp_re;
        int addr;
        reset = rs; start = st; nextIns = ni; branch_req = br; branch_target = tg[9:0];
        #1;
        exp_re = m_started && !m_ended && !m_inflight && ni;
        addr   = m_bp ? m_ba : m_pc;
        chk("imem_re", int'(imem_re), int'(exp_re));
        if (exp_re) chk("imem_addr", int'(imem_addr), addr);
        chk("ins_valid", int'(ins_valid), int'(m_iv));
        chk("instructions", int'(instructions), int'(m_ir[8:6]));
        chk("operand", int'(operand), int'(m_ir[5:0]));
        chk("pc", int'(pc), m_pc);
        chk("done", int'(done), int'(m_ended));
        chk("overrun", int'(overrun), int'(m_ovr));
        s_re = imem_re;
        s_addr = imem_addr;
        if (rs) begin
            model_reset();
        end else begin
            m_iv = 0;
            if (m_inflight) begin
                m_ir = mem[m_fa];
                m_iv = 1;
                m_pc = (m_fa + 1) % 1024;
                if (m_fa == 1023) m_ended = 1;
                if (ni) m_ovr = 1;
                m_inflight = 0;
            end else if (!m_started && st) begin
                m_started = 1;
            end else if (exp_re) begin
                m_inflight = 1;
                m_fa = addr;
                m_bp = 0;
            end
            if (br) begin
                m_bp = 1;
                m_ba = tg % 1024;
            end
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        int exp_op[3];
        int exp_opd[3];
        bit rs, st, ni, br;
        int tg;
        for (int i = 0; i < 1024; i++) mem[i] = 9'($urandom);
        mem[0] = 9'h0A1; mem[1] = 9'h142; mem[2] = 9'h1E3;
        exp_op  = '{2, 5, 7};
        exp_opd = '{6'h21, 6'h02, 6'h23};
        imem_data = '0;
        model_reset();
        reset = 1; start = 0; nextIns = 0; branch_req = 0; branch_target = '0;
        @(negedge clock);

        // reset state and three sequential fetches
        cyc(1, 0, 0, 0, 0);
        chk("rst_pc", int'(pc), 0);
        chk("rst_valid", int'(ins_valid), 0);
        chk("rst_instr", int'(instructions), 0);
        chk("rst_done", int'(done), 0);
        cyc(0, 0, 1, 0, 0);
        chk("idle_no_re", int'(s_re), 0);
        cyc(0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, 0, 0);
            chk("t1_addr", int'(s_addr), k);
            cyc(0, 0, 0, 0, 0);
            chk("t1_valid", int'(ins_valid), 1);
            chk("t1_op", int'(instructions), exp_op[k]);
            chk("t1_operand", int'(operand), exp_opd[k]);
            idle(2);
        end
        chk("t1_pc", int'(pc), 3);

        // branch between fetches
        cyc(0, 0, 0, 1, 'h040);
        cyc(0, 0, 1, 0, 0);
        chk("t2_addr", int'(s_addr), 'h040);
        cyc(0, 0, 0, 0, 0);
        chk("t2_pc", int'(pc), 'h041);
        idle(2);
        cyc(0, 0, 1, 0, 0);
        chk("t2_next", int'(s_addr), 'h041);
        idle(3);

        // branch coincident with nextIns: old source now, target next
        cyc(0, 0, 1, 1, 'h100);
        chk("t3_old", int'(s_addr), 'h042);
        idle(3);
        cyc(0, 0, 1, 0, 0);
        chk("t3_new", int'(s_addr), 'h100);
        idle(3);

        // run to the last address, pc wraps, further requests ignored
        cyc(0, 0, 0, 1, 1020);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 1, 0, 0);
            chk("t4_addr", int'(s_addr), 1020 + k);
            cyc(0, 0, 0, 0, 0);
            chk("t4_valid", int'(ins_valid), 1);
            chk("t4_done", int'(done), (k == 3) ? 1 : 0);
            idle(2);
        end
        chk("t4_wrap_pc", int'(pc), 0);
        cyc(0, 0, 1, 0, 0);
        chk("t4_no_re", int'(s_re), 0);
        cyc(0, 0, 0, 0, 0);
        chk("t4_no_ovr", int'(overrun), 0);
        chk("t4_done_held", int'(done), 1);

        // overrun from a request during the read cycle
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("t5_no_re", int'(s_re), 0);
        chk("t5_ovr", int'(overrun), 1);
        idle(4);
        chk("t5_sticky", int'(overrun), 1);
        cyc(1, 0, 0, 0, 0);
        chk("t5_clear", int'(overrun), 0);

        // reset in the read cycle
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        idle(3);
        chk("t6_loaded", int'(instructions), 2);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("t6_pc", int'(pc), 0);
        chk("t6_valid", int'(ins_valid), 0);
        chk("t6_instr", int'(instructions), 0);
        chk("t6_operand", int'(operand), 0);
        cyc(0, 0, 1, 0, 0);
        chk("t6_idle_re", int'(s_re), 0);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rs = ($urandom_range(0, 299) == 0);
            st = ($urandom_range(0, 9) == 0);
            ni = ($urandom_range(0, 2) == 0);
            br = ($urandom_range(0, 7) == 0);
            tg = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1016, 1023))
                                              : int'($urandom_range(0, 1023));
            cyc(rs, st, ni, br, tg);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
